// File: rtl/ascii2bcd_pkg.sv
// ascii2bcd_pkg
// Shared definitions for the ASCII-to-packed-BCD receive parser:
//   - ASCII code points used by the character classifier
//   - FSM state encoding used by ascii2bcd_parser
package ascii2bcd_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/ascii2bcd_parser_if.sv
// ascii2bcd_parser_if
// Bundles the character input stream and the BCD result outputs of the
// parser.
//   master : character source / result consumer (drives rx_*, reads results)
//   slave  : the parser (reads rx_*, drives bcd, bcd_valid, digit_cnt, neg, err)
// Signals:
//   rx_data[7:0]     ASCII character
//   rx_valid         rx_data valid this cycle, no back-pressure
//   bcd[4*DIGITS-1:0] packed BCD result, LSD in [3:0]
//   bcd_valid        one-cycle pulse on release
//   digit_cnt        digits in the released number
//   neg              released number carried a leading '-'
//   err              one-cycle pulse on entry to the error state
interface ascii2bcd_parser_if #(
  parameter int DIGITS = 4
);

  logic [7:0]                     rx_data;
  logic                           rx_valid;
  logic [4*DIGITS-1:0]            bcd;
  logic                           bcd_valid;
  logic [$clog2(DIGITS+1)-1:0]    digit_cnt;
  logic                           neg;
  logic                           err;

  modport master (
    output rx_data, rx_valid,
    input  bcd, bcd_valid, digit_cnt, neg, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output bcd, bcd_valid, digit_cnt, neg, err
  );

endinterface

// File: rtl/ascii2bcd_parser_classify.sv
// ascii_char_classify
// Purely combinational one-hot classification of an ASCII character.
// Ports:
//   char_i[7:0] : character to classify
//   is_digit_o  : '0'..'9'
//   is_term_o   : CR or LF
//   is_minus_o  : '-'
//   is_other_o  : anything else
module ascii_char_classify
  import ascii2bcd_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_term_o,
  output logic       is_minus_o,
  output logic       is_other_o
);

  always_comb begin
    is_digit_o = (char_i >= ASCII_0) && (char_i <= ASCII_9);
    is_term_o  = (char_i == ASCII_CR) || (char_i == ASCII_LF);
    is_minus_o = (char_i == ASCII_MINUS);
    is_other_o = !(is_digit_o || is_term_o || is_minus_o);
  end

endmodule

// File: rtl/ascii2bcd_parser.sv
// ascii2bcd_parser
// Assembles a stream of ASCII digits into a right-aligned packed BCD word,
// released on a CR/LF terminator. Malformed lines raise a one-cycle err pulse
// and are discarded up to the next terminator.
// Optional feature: define ASCII2BCD_SIGN_EN to accept a leading '-' and
// report it on neg; otherwise '-' is an error and neg is tied to 0.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : ascii2bcd_parser_if.slave (rx_data/rx_valid in, result outputs)
module ascii2bcd_parser
  import ascii2bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic               clk,
  input logic               rst,
  ascii2bcd_parser_if.slave bus
);

  localparam int                CNT_W   = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIGITS);

  logic is_digit, is_term, is_minus, is_other;

  ascii_char_classify u_classify (
    .char_i     (bus.rx_data),
    .is_digit_o (is_digit),
    .is_term_o  (is_term),
    .is_minus_o (is_minus),
    .is_other_o (is_other)
  );

  state_e              state_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [CNT_W-1:0]    digit_cnt_q;
  logic                bcd_valid_q;
  logic                err_q;
  logic [3:0]          nib;

  assign nib = bus.rx_data[3:0];

`ifdef ASCII2BCD_SIGN_EN
  logic sign_q;
  logic neg_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      digit_cnt_q <= '0;
      bcd_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef ASCII2BCD_SIGN_EN
      sign_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      bcd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (bus.rx_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (is_digit) begin
              acc_q   <= {{(4*DIGITS-4){1'b0}}, nib};
              cnt_q   <= CNT_W'(1);
              state_q <= ST_ACCUM;
            end else if (is_term) begin
              // Empty line: nothing to release.
              state_q <= ST_IDLE;
`ifdef ASCII2BCD_SIGN_EN
            end else if (is_minus) begin
              sign_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_ACCUM;
`endif
            end else begin
              // Without signed support '-' lands here as well.
              err_q   <= 1'b1;
              state_q <= ST_ERROR;
            end
          end

          ST_ACCUM: begin
            if (is_digit) begin
              if (cnt_q < CNT_MAX) begin
                acc_q <= {acc_q[4*DIGITS-5:0], nib};
                cnt_q <= cnt_q + CNT_W'(1);
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_ERROR;
              end
            end else if (is_term) begin
              if (cnt_q != '0) begin
                bcd_q       <= acc_q;
                digit_cnt_q <= cnt_q;
                bcd_valid_q <= 1'b1;
`ifdef ASCII2BCD_SIGN_EN
                neg_q       <= sign_q;
`endif
              end else begin
                // Lone '-': the terminator is consumed, so go straight home.
                err_q <= 1'b1;
              end
              acc_q   <= '0;
              cnt_q   <= '0;
`ifdef ASCII2BCD_SIGN_EN
              sign_q  <= 1'b0;
`endif
              state_q <= ST_IDLE;
            end else if (is_minus || is_other) begin
              err_q   <= 1'b1;
              state_q <= ST_ERROR;
            end
          end

          ST_ERROR: begin
            if (is_term) begin
              acc_q   <= '0;
              cnt_q   <= '0;
`ifdef ASCII2BCD_SIGN_EN
              sign_q  <= 1'b0;
`endif
              state_q <= ST_IDLE;
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.err       = err_q;
`ifdef ASCII2BCD_SIGN_EN
  assign bus.neg       = neg_q;
`else
  assign bus.neg       = 1'b0;
`endif

endmodule

// File: tb/tb_ascii2bcd_parser.sv
// tb_ascii2bcd_parser
// Directed, table-driven bench for ascii2bcd_parser with DIGITS=4.
// Each table row applies one character slot and lists the outputs expected
// one clock later. Reset behaviour is exercised by hand-written sequences.
module tb_ascii2bcd_parser;

  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ascii2bcd_parser_if #(.DIGITS(DIGITS)) bus ();

  ascii2bcd_parser #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  ch;
    logic        vld;
    logic        e_bv;
    logic        e_err;
    logic [15:0] e_bcd;
    logic [2:0]  e_cnt;
    logic        e_neg;
  } rec_t;

  rec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic [7:0] ch, input logic vld, input logic bv,
                              input logic er, input logic [15:0] b, input logic [2:0] c,
                              input logic n);
    rec_t r;
    r.ch = ch; r.vld = vld; r.e_bv = bv; r.e_err = er;
    r.e_bcd = b; r.e_cnt = c; r.e_neg = n;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic bv, input logic er,
                               input logic [15:0] b, input logic [2:0] c, input logic n);
    chk("bcd_valid", idx, 32'(bus.bcd_valid), 32'(bv));
    chk("err",       idx, 32'(bus.err),       32'(er));
    chk("bcd",       idx, 32'(bus.bcd),       32'(b));
    chk("digit_cnt", idx, 32'(bus.digit_cnt), 32'(c));
    chk("neg",       idx, 32'(bus.neg),       32'(n));
  endtask

  task automatic step(input int idx, input logic [7:0] ch, input logic vld, input logic bv,
                      input logic er, input logic [15:0] b, input logic [2:0] c,
                      input logic n);
    @(negedge clk);
    bus.rx_data  = ch;
    bus.rx_valid = vld;
    @(posedge clk);
    #1;
    check_outputs(idx, bv, er, b, c, n);
  endtask

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Test 1: "123" CR, then an idle slot to show the pulse is single-cycle.
    add("1", 1, 0, 0, 16'h0000, 0, 0);
    add("2", 1, 0, 0, 16'h0000, 0, 0);
    add("3", 1, 0, 0, 16'h0000, 0, 0);
    add(CR,  1, 1, 0, 16'h0123, 3, 0);
    add(0,   0, 0, 0, 16'h0123, 3, 0);
    // Test 2: five digits overflow; line discarded; then "9" CR.
    add("1", 1, 0, 0, 16'h0123, 3, 0);
    add("2", 1, 0, 0, 16'h0123, 3, 0);
    add("3", 1, 0, 0, 16'h0123, 3, 0);
    add("4", 1, 0, 0, 16'h0123, 3, 0);
    add("5", 1, 0, 1, 16'h0123, 3, 0);
    add(LF,  1, 0, 0, 16'h0123, 3, 0);
    add("9", 1, 0, 0, 16'h0123, 3, 0);
    add(CR,  1, 1, 0, 16'h0009, 1, 0);
    // Test 3: illegal character mid-line, then "08" LF.
    add("4", 1, 0, 0, 16'h0009, 1, 0);
    add("A", 1, 0, 1, 16'h0009, 1, 0);
    add("7", 1, 0, 0, 16'h0009, 1, 0);
    add(CR,  1, 0, 0, 16'h0009, 1, 0);
    add("0", 1, 0, 0, 16'h0009, 1, 0);
    add("8", 1, 0, 0, 16'h0009, 1, 0);
    add(LF,  1, 1, 0, 16'h0008, 2, 0);
    // Test 4: empty lines in IDLE.
    add(CR,  1, 0, 0, 16'h0008, 2, 0);
    add(LF,  1, 0, 0, 16'h0008, 2, 0);
    add(CR,  1, 0, 0, 16'h0008, 2, 0);
    // Full-width number, then a digit immediately after the terminator.
    add("9", 1, 0, 0, 16'h0008, 2, 0);
    add("8", 1, 0, 0, 16'h0008, 2, 0);
    add("7", 1, 0, 0, 16'h0008, 2, 0);
    add("6", 1, 0, 0, 16'h0008, 2, 0);
    add(CR,  1, 1, 0, 16'h9876, 4, 0);
    add("1", 1, 0, 0, 16'h9876, 4, 0);
    add(LF,  1, 1, 0, 16'h0001, 1, 0);
    // Leading zeros kept; a gap (rx_valid=0 with a junk byte) holds state.
    add("0", 1, 0, 0, 16'h0001, 1, 0);
    add("A", 0, 0, 0, 16'h0001, 1, 0);
    add("0", 1, 0, 0, 16'h0001, 1, 0);
    add("7", 1, 0, 0, 16'h0001, 1, 0);
    add(CR,  1, 1, 0, 16'h0007, 3, 0);
`ifdef ASCII2BCD_SIGN_EN
    // Test 5 (signed build).
    add("-", 1, 0, 0, 16'h0007, 3, 0);
    add("4", 1, 0, 0, 16'h0007, 3, 0);
    add("2", 1, 0, 0, 16'h0007, 3, 0);
    add(CR,  1, 1, 0, 16'h0042, 2, 1);
    add("-", 1, 0, 0, 16'h0042, 2, 1);
    add(CR,  1, 0, 1, 16'h0042, 2, 1);
    add("5", 1, 0, 0, 16'h0042, 2, 1);
    add("-", 1, 0, 1, 16'h0042, 2, 1);
    add(CR,  1, 0, 0, 16'h0042, 2, 1);
    add("7", 1, 0, 0, 16'h0042, 2, 1);
    add(CR,  1, 1, 0, 16'h0007, 1, 0);
`else
    // Test 5 (unsigned build): '-' is an ordinary illegal character.
    add("-", 1, 0, 1, 16'h0007, 3, 0);
    add("4", 1, 0, 0, 16'h0007, 3, 0);
    add(CR,  1, 0, 0, 16'h0007, 3, 0);
    add("7", 1, 0, 0, 16'h0007, 3, 0);
    add(CR,  1, 1, 0, 16'h0007, 1, 0);
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    check_outputs(-1, 0, 0, 16'h0000, 0, 0);
    rst = 1'b0;

    foreach (tbl[i])
      step(i, tbl[i].ch, tbl[i].vld, tbl[i].e_bv, tbl[i].e_err,
           tbl[i].e_bcd, tbl[i].e_cnt, tbl[i].e_neg);

    // Test 6: reset mid-number clears outputs asynchronously.
    step(100, "5", 1, 0, 0, 16'h0007, 1, 0);
    step(101, "6", 1, 0, 0, 16'h0007, 1, 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_outputs(102, 0, 0, 16'h0000, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(103, CR,  1, 0, 0, 16'h0000, 0, 0);
    step(104, "3", 1, 0, 0, 16'h0000, 0, 0);
    step(105, CR,  1, 1, 0, 16'h0003, 1, 0);
    step(106, 0,   0, 0, 0, 16'h0003, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
